pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 122 ++++++++++++
 tb/tb_pwm_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// pwm_gen: single-counter PWM generator with a double-buffered duty value.
// The counter runs 0..period_r, and each pass is one PWM period.
// New duty values arrive over a valid/ready handshake into a one-entry shadow
// register. They only take effect at a period boundary, so a period is never
// cut short or stretched by an update.
module pwm_gen #(
  parameter int WIDTH      = 8,
  parameter int PERIOD_MIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             S,
  output logic             cycle_start,
  output logic             active
);

  localparam logic [WIDTH-1:0] PMIN = WIDTH'(PERIOD_MIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] shadow;
  logic             pending;

  logic             running;
  logic             wrap;
  logic             start;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] period_clamped;

  // Period-boundary and handshake decode shared by every register below.
  always_comb begin
    running        = (state != IDLE);
    wrap           = running && (cnt == period_r);
    start          = (state == IDLE) && en;
    load           = start || wrap;
    xfer           = duty_valid && !pending;
    period_clamped = (period < PMIN) ? PMIN : period;
  end

  // Next-state logic: RUN/DRAIN differ only in whether the wrap ends the run.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN: begin
        if (en)        state_next = RUN;
        else if (wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops sample pre-edge values together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Period counter: parked at 0 in IDLE and reloads 0 on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!running || wrap) cnt <= '0;
    else                      cnt <= cnt + WIDTH'(1);
  end

  // Period and duty snapshots. They only move at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r <= PMIN;
      duty_r   <= '0;
    end else if (load) begin
      period_r <= period_clamped;
      if (pending) duty_r <= shadow;
    end
  end

  // Shadow register and pending flag. A boundary consumes the old shadow
  // before a capture on the same edge can overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= duty;
      pending <= 1'b1;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  // Registered PWM command. Comparing before the counter advances gives
  // exactly duty_r high cycles per period. When duty_r exceeds period_r the
  // output stays high across the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                S <= 1'b0;
    else if (!running || state_next == IDLE)   S <= 1'b0;
    else                                       S <= (cnt < duty_r);
  end

  assign duty_ready  = !pending;
  assign active      = running;
  assign cycle_start = running && (cnt == '0);

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed checks of pwm_gen (WIDTH=8, PERIOD_MIN=1).
// Waveforms are collected into bit vectors, with bit i = the sample i cycles into
// the window. Each vector is compared against a hand-derived constant.
module tb_pwm_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] period;
  logic [7:0] duty;
  logic       duty_valid;
  logic       duty_ready;
  logic       S;
  logic       cycle_start;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_gen #(.WIDTH(8), .PERIOD_MIN(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .S           (S),
    .cycle_start (cycle_start),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: the rising edge, then the falling edge where we sample and drive.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] sv20, cs20, rv20, av20;
  logic [31:0] sv32;
  logic [9:0]  sv10, cs10;
  logic [11:0] av12, rv12;
  logic [23:0] sv24;

  initial begin
    rst_n = 1'b0; en = 1'b0; period = 8'd9; duty = 8'd0; duty_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s",           {31'd0, S},           32'd0);
    check("rst_active",      {31'd0, active},      32'd0);
    check("rst_cycle_start", {31'd0, cycle_start}, 32'd0);
    check("rst_ready",       {31'd0, duty_ready},  32'd1);

    // Basic pattern: period 9, duty 3 handshaken while idle.
    rst_n = 1'b1; duty = 8'd3; duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
    check("idle_ready_low", {31'd0, duty_ready}, 32'd0);
    check("idle_active",    {31'd0, active},     32'd0);
    en = 1'b1;
    cyc();  // edge A: IDLE -> RUN
    check("start_cs",     {31'd0, cycle_start}, 32'd1);
    check("start_active", {31'd0, active},      32'd1);
    check("start_s",      {31'd0, S},           32'd0);
    check("start_ready",  {31'd0, duty_ready},  32'd1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      sv20[k-1] = S;
      cs20[k-1] = cycle_start;
    end
    check("d3_s_pattern",  {12'd0, sv20}, {12'd0, 20'b00000001110000000111});
    check("d3_cs_pattern", {12'd0, cs20}, {12'd0, 20'b10000000001000000000});

    // Mid-period handshake of duty 7: current period keeps 3, next has 7.
    for (int k = 21; k <= 40; k++) begin
      cyc();
      sv20[k-21] = S;
      rv20[k-21] = duty_ready;
      if (k == 24) begin duty = 8'd7; duty_valid = 1'b1; end
      if (k == 25) duty_valid = 1'b0;
    end
    check("d7_s_pattern",     {12'd0, sv20}, {12'd0, 20'b00011111110000000111});
    check("d7_ready_pattern", {12'd0, rv20}, {12'd0, 20'b11111111111000001111});

    // Duty 0 for a full period, then 12 (> period) held high across wraps.
    for (int k = 41; k <= 72; k++) begin
      cyc();
      sv32[k-41] = S;
      if (k == 41) begin duty = 8'd0; duty_valid = 1'b1; end
      if (k == 42) duty_valid = 1'b0;
      if (k == 50) begin duty = 8'd12; duty_valid = 1'b1; end
      if (k == 51) duty_valid = 1'b0;
      if (k == 72) begin duty = 8'd3; duty_valid = 1'b1; end
    end
    check("d0_d12_s_pattern", sv32, 32'hFFF0007F);

    // Stop request at cnt=4: the period completes, then the block goes idle.
    for (int k = 73; k <= 92; k++) begin
      cyc();
      if (k == 73) duty_valid = 1'b0;
      if (k == 84) en = 1'b0;
      if (k >= 81 && k <= 90) sv10[k-81] = S;
      if (k >= 81) av12[k-81] = active;
    end
    check("drain_s_pattern",      {22'd0, sv10}, {22'd0, 10'b0000000111});
    check("drain_active_pattern", {20'd0, av12}, {20'd0, 12'h1FF});
    check("idle_s",  {31'd0, S},           32'd0);
    check("idle_cs", {31'd0, cycle_start}, 32'd0);

    // Second run: drop en at cnt=2, re-raise at cnt=6, expect no gap.
    en = 1'b1;
    cyc();  // edge B
    for (int j = 1; j <= 22; j++) begin
      cyc();
      if (j <= 20) begin
        sv20[j-1] = S;
        cs20[j-1] = cycle_start;
        av20[j-1] = active;
      end
      if (j == 2)  en = 1'b0;
      if (j == 6)  en = 1'b1;
      if (j == 20) begin duty = 8'd9; duty_valid = 1'b1; end
      if (j == 21) duty_valid = 1'b0;
    end
    check("rerun_s_pattern",      {12'd0, sv20}, {12'd0, 20'b00000001110000000111});
    check("rerun_cs_pattern",     {12'd0, cs20}, {12'd0, 20'b10000000001000000000});
    check("rerun_active_pattern", {12'd0, av20}, {12'd0, 20'hFFFFF});

    // Asynchronous reset mid-period while S is high and a duty is pending.
    check("pre_rst_s",     {31'd0, S},          32'd1);
    check("pre_rst_ready", {31'd0, duty_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_s",      {31'd0, S},           32'd0);
    check("async_rst_active", {31'd0, active},      32'd0);
    check("async_rst_cs",     {31'd0, cycle_start}, 32'd0);
    check("async_rst_ready",  {31'd0, duty_ready},  32'd1);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_s",      {31'd0, S},      32'd0);
      check("post_rst_active", {31'd0, active}, 32'd0);
    end

    // Restart with duty 4. Then offer 5 while pending is clear, and hold
    // valid with 2 through the wrap while 5 is still pending.
    duty = 8'd4; duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0; en = 1'b1;
    cyc();  // edge C
    check("lat_cs",    {31'd0, cycle_start}, 32'd1);
    check("lat_s",     {31'd0, S},           32'd0);
    check("lat_ready", {31'd0, duty_ready},  32'd1);
    for (int c = 1; c <= 24; c++) begin
      cyc();
      sv24[c-1] = S;
      if (c <= 12) rv12[c-1] = duty_ready;
      if (c == 1)  begin duty = 8'd5; duty_valid = 1'b1; end
      if (c == 2)  duty = 8'd2;
      if (c == 11) duty_valid = 1'b0;
      if (c == 24) period = 8'd0;
    end
    check("wrap_hs_s_pattern",     {8'd0, sv24},  {8'd0, 24'h307C0F});
    check("wrap_hs_ready_pattern", {20'd0, rv12}, {20'd0, 12'h201});

    // A period request of 0 is clamped to 1, giving a two-cycle period.
    for (int c = 25; c <= 34; c++) begin
      cyc();
      cs10[c-25] = cycle_start;
    end
    check("clamp_cs_pattern", {22'd0, cs10}, {22'd0, 10'h2A0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
